// File: rtl/uart_tx_scheduler_if.sv
// Producer-side handshake and line-side status of the shared UART transmitter.
// The producers drive the master modport and the scheduler implements the slave modport.
interface uart_tx_scheduler_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0_valid,
    output req0_data,
    output req1_valid,
    output req1_data,
    input  req0_ready,
    input  req1_ready,
    input  tx,
    input  busy,
    input  grant_id
  );

  modport slave (
    input  req0_valid,
    input  req0_data,
    input  req1_valid,
    input  req1_data,
    output req0_ready,
    output req1_ready,
    output tx,
    output busy,
    output grant_id
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a single 8N1 UART transmitter.
// A byte is accepted only in IDLE, and frames run START, DATA x8, STOP at CLKS_PER_BIT cycles per bit.
module uart_tx_scheduler #(
  parameter int unsigned SYSTEM_CLK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE       = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus
);

  localparam int unsigned CLKS_PER_BIT = SYSTEM_CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cfg_check
    $error("uart_tx_scheduler: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic             ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             tx_q,      tx_d;
  logic             grant_q,   grant_d;

  logic             sel_any;
  logic             sel_id;
  logic [7:0]       sel_data;
  logic             accept;
  logic             bit_end;

  // Pick at most one requester; the pointer only matters when both are valid.
  always_comb begin
    sel_any = 1'b0;
    sel_id  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        sel_any = 1'b1;
        sel_id  = ptr_q;
      end else if (bus.req0_valid) begin
        sel_any = 1'b1;
        sel_id  = 1'b0;
      end else if (bus.req1_valid) begin
        sel_any = 1'b1;
        sel_id  = 1'b1;
      end else begin
        sel_any = 1'b0;
        sel_id  = 1'b0;
      end
    end else begin
      sel_any = 1'b0;
      sel_id  = 1'b0;
    end
  end

  assign bus.req0_ready = sel_any && !sel_id && !rst;
  assign bus.req1_ready = sel_any &&  sel_id && !rst;
  assign accept         = sel_any && !rst;
  assign sel_data       = sel_id ? bus.req1_data : bus.req0_data;
  assign bit_end        = (cnt_q == CNT_LAST);

  // Frame sequencer: tx is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    grant_d   = grant_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (accept) begin
          state_d   = ST_START;
          shift_d   = sel_data;
          grant_d   = sel_id;
          ptr_d     = ~sel_id;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
        end else begin
          tx_d      = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      grant_q   <= grant_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.grant_id = grant_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between two byte requesters, for example the core's debug/print path and a memory-dump engine.
- Round-robin arbitration between the two requesters.
- Internal baud-tick counter derived from the system clock.
- FSM that sequences each accepted byte as an 8N1 frame.

The block sits between the processor-side producers and the board TX pin.

Parameters:
- SYSTEM_CLK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLKS_PER_BIT, derived localparam = SYSTEM_CLK_FREQ / BAUD_RATE, truncating integer division (13020 at defaults).
  - Must be >= 2.
  - Elaboration error otherwise.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte; held stable while req0_valid && !req0_ready.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte; same hold rule.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- grant_id  out  1  requester owning the current/last frame.

Behaviour:
- Reset (async, while rst=1):
  - State = IDLE; tx=1; busy=0; grant_id=0.
  - Round-robin pointer = 0; baud counter = 0; bit index = 0; shift register = 0.
  - req0_ready = req1_ready = 0.
- States: IDLE, START, DATA, STOP. busy = (state != IDLE), decoded from the state register.
- Arbitration (IDLE only):
  - reqN_ready is combinational: state==IDLE && rst==0 && requester N selected.
  - Only one requester is selected:
    - If only one valid, select it.
    - If both valid, select the one equal to the pointer.
    - If none valid, neither ready.
  - Transfer happens on the posedge where valid && ready.
  - Ready never asserts outside IDLE, so at most one ready is high per cycle.
- On transfer (registered at that edge):
  - Shift register <= selected data; grant_id <= selected id.
  - Pointer <= ~selected id; baud counter <= 0; state <= START.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1 in START/DATA/STOP.
  - At CLKS_PER_BIT-1 it wraps to 0 and the bit-end event fires.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- START:
  - tx=0, registered, so tx falls the cycle after the transfer edge.
  - On bit-end go to DATA with bit index 0.
- DATA:
  - tx = shift[0], LSB first.
  - On each bit-end: shift >> 1, bit index +1.
  - After the bit-end with index 7, go to STOP.
- STOP:
  - tx=1.
  - On bit-end go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles of START..STOP.
  - Back-to-back frames are separated by exactly 1 extra idle cycle (the IDLE accept cycle).
  - Sustained throughput is one byte per 10*CLKS_PER_BIT+1 cycles.
- Valid dropped without transfer: permitted, no effect. Data is sampled only at the transfer edge.
- Request arriving while busy: waits with ready=0; no loss and no reordering within a requester.
- Reset mid-frame:
  - Immediate tx=1, state IDLE, pointer 0.
  - The partial frame is abandoned; the byte is not retried.
- grant_id holds its value after the frame ends until the next transfer.

Test Plan:
Bench parameters: SYSTEM_CLK_FREQ=16, BAUD_RATE=4, so CLKS_PER_BIT=4.
1. Reset release, no valids for 20 cycles -> tx=1, busy=0, both readys 0, grant_id=0.
2. req0 sends 0xA5 alone:
   - req0_ready=1 for 1 cycle.
   - tx over 40 cycles, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
   - busy high for 40 cycles; grant_id=0.
3. Both valid from reset, holding distinct bytes 0x11 (req0) and 0x22 (req1):
   - Grants in order req0, req1, req0.
   - Frame starts 41 cycles apart.
   - Each ready pulses once per grant.
4. Request during a frame: req1 asserts 5 cycles into a req0 frame -> req1_ready stays 0 until the IDLE cycle after STOP, then is accepted; its start bit begins the next cycle.
5. Reset mid-frame: assert rst at cycle 15 of a frame -> tx=1 within the same cycle (async), busy=0. After release, a new req1 byte 0x0F transmits a full correct frame.
6. Edge: data changes while valid=0 and only the final value is presented with valid -> only that value appears on tx. A 0x00 byte gives a 36-cycle low run then 4 high.
